// File: rtl/dv_sim_ctrl_pkg.sv
// Shared constants and types for the DV simulation-control Wishbone responder.
// Register offsets are byte offsets inside the 256-byte window.
package dv_sim_ctrl_pkg;

  localparam logic [7:0] OFF_TOHOST   = 8'h00;
  localparam logic [7:0] OFF_CONSOLE  = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH  = 8'h10;
  localparam logic [7:0] OFF_WATCHDOG = 8'h14;

  localparam logic [30:0] WDOG_CODE = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int unsigned i = 0; i < 4; i++)
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dv_sim_ctrl_wb_if.sv
// Wishbone B4 pipelined bus bundle for the simulation-control responder.
interface dv_sim_ctrl_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;

  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
                  input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o);
  modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
                  output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o);
endinterface

// File: rtl/dv_sim_ctrl_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full (and not popping)
// is discarded and flagged on o_drop.
module dv_sim_ctrl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & o_full & ~w_pop;
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/dv_sim_ctrl_wb.sv
// Wishbone B4 pipelined responder for the DV simulation-control region
// (TOHOST, console FIFO, cycle counter, scratch). DV_SIM_CTRL_WATCHDOG_EN adds a watchdog.
module dv_sim_ctrl_wb
  import dv_sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned ACK_LATENCY = 1,
  parameter int unsigned CON_DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dv_sim_ctrl_wb_if.slave    wb,
  output logic               test_done_o,
  output logic               test_pass_o,
  output logic [30:0]        test_code_o,
  output logic               con_valid_o,
  output logic [7:0]         con_data_o,
  input  logic               con_ready_i,
  output logic               con_overflow_o
);
  state_e      r_state;
  logic [1:0]  r_wait;
  logic        r_ack, r_err, r_rsp_err;
  logic [31:0] r_dat, r_rsp_dat;
  logic        r_done, r_pass, r_ovf;
  logic [30:0] r_code;
  logic [63:0] r_cycle;
  logic [31:0] r_shadow, r_scratch;

  logic        w_accept, w_hit, w_err;
  logic [7:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_push, w_tohost_wr, w_scr_we, w_shadow_ld;
  logic        w_empty, w_full, w_drop;
  logic [7:0]  w_fifo_data;
  logic        w_unused;
`ifdef DV_SIM_CTRL_WATCHDOG_EN
  logic [31:0] r_wdog, r_wd_cnt;
  logic        r_wd_arm;
  logic        w_wd_we;
  logic [31:0] w_wd_val;
  assign w_wd_val = byte_merge(r_wdog, wb.wb_dat_i, wb.wb_sel_i);
`endif

  assign w_accept = wb.wb_cyc_i & wb.wb_stb_i & (r_state == IDLE);
  assign w_hit    = (wb.wb_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_off    = {wb.wb_adr_i[7:2], 2'b00};
  assign w_unused = ^wb.wb_adr_i[1:0];

  always_comb begin
    w_err       = 1'b0;
    w_rdata     = '0;
    w_push      = 1'b0;
    w_tohost_wr = 1'b0;
    w_scr_we    = 1'b0;
    w_shadow_ld = 1'b0;
`ifdef DV_SIM_CTRL_WATCHDOG_EN
    w_wd_we     = 1'b0;
`endif
    if (!w_hit) begin
      w_err = 1'b1;
    end else begin
      case (w_off)
        OFF_TOHOST:   if (wb.wb_we_i) begin
                        if (wb.wb_sel_i != 4'hF) w_err = 1'b1;
                        else                     w_tohost_wr = 1'b1;
                      end
        OFF_CONSOLE:  w_push = wb.wb_we_i & wb.wb_sel_i[0];
        OFF_CYCLE_LO: if (wb.wb_we_i) w_err = 1'b1;
                      else begin
                        w_rdata     = r_cycle[31:0];
                        w_shadow_ld = 1'b1;
                      end
        OFF_CYCLE_HI: if (wb.wb_we_i) w_err = 1'b1;
                      else            w_rdata = r_shadow;
        OFF_SCRATCH:  if (wb.wb_we_i) w_scr_we = 1'b1;
                      else            w_rdata  = r_scratch;
`ifdef DV_SIM_CTRL_WATCHDOG_EN
        OFF_WATCHDOG: if (wb.wb_we_i) w_wd_we = 1'b1;
                      else            w_rdata = r_wdog;
`endif
        default:      w_err = 1'b1;
      endcase
    end
  end

  // Response is decided at acceptance and replayed after the latency delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_rsp_err <= w_err;
          r_rsp_dat <= w_rdata;
          if (ACK_LATENCY > 1) begin
            r_state <= WAIT;
            r_wait  <= 2'(ACK_LATENCY - 1);
          end else begin
            r_state <= RESP;
            r_ack   <= ~w_err;
            r_err   <= w_err;
            r_dat   <= w_rdata;
          end
        end
        WAIT: if (!wb.wb_cyc_i) begin
          r_state <= IDLE;
        end else if (r_wait == 2'd1) begin
          r_state <= RESP;
          r_ack   <= ~r_rsp_err;
          r_err   <= r_rsp_err;
          r_dat   <= r_rsp_dat;
        end else begin
          r_wait <= r_wait - 2'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_shadow  <= '0;
      r_scratch <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_code    <= '0;
      r_ovf     <= 1'b0;
`ifdef DV_SIM_CTRL_WATCHDOG_EN
      r_wdog    <= '0;
      r_wd_cnt  <= '0;
      r_wd_arm  <= 1'b0;
`endif
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_accept && w_shadow_ld) r_shadow  <= r_cycle[63:32];
      if (w_accept && w_scr_we)    r_scratch <= byte_merge(r_scratch, wb.wb_dat_i, wb.wb_sel_i);
      if (w_drop)                  r_ovf     <= 1'b1;
`ifdef DV_SIM_CTRL_WATCHDOG_EN
      if (w_accept && w_wd_we) begin
        r_wdog   <= w_wd_val;
        r_wd_cnt <= w_wd_val;
        r_wd_arm <= |w_wd_val;
      end else if (r_wd_arm) begin
        if (r_wd_cnt == 32'd1) begin
          r_wd_arm <= 1'b0;
          r_wd_cnt <= '0;
          if (!r_done) begin
            r_done <= 1'b1;
            r_pass <= 1'b0;
            r_code <= WDOG_CODE;
          end
        end else begin
          r_wd_cnt <= r_wd_cnt - 32'd1;
        end
      end
`endif
      if (w_accept && w_tohost_wr && (|wb.wb_dat_i) && !r_done) begin
        r_done <= 1'b1;
        r_pass <= (wb.wb_dat_i == 32'd1);
        r_code <= wb.wb_dat_i[31:1];
      end
    end
  end

  dv_sim_ctrl_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept & w_push),
    .i_data  (wb.wb_dat_i[7:0]),
    .i_pop   (con_ready_i),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign wb.wb_stall_o  = (r_state != IDLE);
  assign wb.wb_ack_o    = r_ack;
  assign wb.wb_err_o    = r_err;
  assign wb.wb_dat_o    = r_dat;
  assign test_done_o    = r_done;
  assign test_pass_o    = r_pass;
  assign test_code_o    = r_code;
  assign con_valid_o    = ~w_empty;
  assign con_data_o     = w_empty ? 8'h00 : w_fifo_data;
  assign con_overflow_o = r_ovf;
endmodule

// File: doc/dv_sim_ctrl_wb.md
Name: dv_sim_ctrl_wb

Overview:
Wishbone B4 pipelined responder (slave) for the simulation-control region of the DV data bus. It sits behind the data-side Wishbone adapter, in parallel with the data memory. The core ends a test by writing TOHOST and emits console bytes through a FIFO. It also reads a free-running 64-bit cycle counter and a scratch register. The bench uses test_done_o/test_pass_o for termination instead of bus snooping.

Parameters:
BASE_ADDR, 32'h2000_0000, byte base of 256-byte window; bits [7:0] must be 0
ACK_LATENCY, 1, cycles from acceptance to ack/err; legal 1..4
CON_DEPTH, 16, console FIFO depth; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane selects
wb_stall_o  out  1  stall
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_dat_o  out  32  read data, valid with ack
test_done_o  out  1  sticky: TOHOST written
test_pass_o  out  1  sticky: TOHOST value == 1
test_code_o  out  31  TOHOST[31:1] of the first completing write
con_valid_o  out  1  console byte available
con_data_o  out  8  console byte (FIFO head)
con_ready_i  in  1  console sink ready
con_overflow_o  out  1  sticky: console byte dropped

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; counter 0; SCRATCH 0.
- Acceptance: at a clk edge with cyc&stb&!stall. wb_stall_o = (state != IDLE). At most one transaction is outstanding.
- FSM states:
  - IDLE -> WAIT on accept if ACK_LATENCY>1, else IDLE -> RESP.
  - WAIT counts ACK_LATENCY-1 cycles, then -> RESP.
  - RESP drives ack or err high for exactly one cycle, then -> IDLE.
  - Ack therefore asserts in cycle accept+ACK_LATENCY. Throughput is one transfer per ACK_LATENCY+1 cycles.
- Cyc deasserted in WAIT or RESP: abort to IDLE next edge; no ack/err. Write side effects are not undone.
- Side effects: write side effects and read data capture occur at the acceptance edge. wb_dat_o holds captured data only during the ack cycle and is 0 otherwise.
- Address decode:
  - adr[31:8] != BASE_ADDR[31:8], or an unmapped offset -> err, no side effect.
  - adr[1:0] are ignored.
- Register map (offset, access):
  - 0x00 TOHOST (W; read returns 0):
    - Requires sel==4'hF, else err.
    - First nonzero write sets done, pass=(val==1), code=val[31:1].
    - Later writes and zero writes are acked with no effect.
  - 0x04 CONSOLE (W):
    - If sel[0], push dat_i[7:0].
    - If the FIFO is full: drop the byte, set con_overflow_o, still ack.
    - sel[0]==0: ack, no push.
  - 0x08 CYCLE_LO (R): returns counter[31:0] and latches counter[63:32] into a shadow.
  - 0x0C CYCLE_HI (R): returns the shadow.
  - Writes to 0x08 and 0x0C -> err.
  - 0x10 SCRATCH (RW): per-byte write per sel.
  - 0x14 WATCHDOG (RW): exists only with the optional feature, else err.
- Counter: 64-bit, increments every cycle after reset and wraps to 0.
- Console FIFO:
  - Pop when con_valid_o&con_ready_i.
  - Push and pop in the same cycle while full succeeds with no overflow.
  - con_data_o is stable while con_valid_o && !con_ready_i.
- Reset mid-transaction: immediate return to IDLE with no ack. FIFO, sticky flags and counter cleared.

Optional Feature:
DV_SIM_CTRL_WATCHDOG_EN
- Defined:
  - WATCHDOG register at 0x14, 32-bit, reset 0.
  - Nonzero value arms a down-counter loaded on each write to it, decremented each cycle.
  - On reaching 0 with done clear: set test_done_o=1, test_pass_o=0, test_code_o=31'h7FFF_FFFF. Then disarm.
  - Writing 0 disarms.
- Undefined: offset 0x14 returns err; no watchdog logic is present.

Decomposition:
- Package dv_sim_ctrl_pkg:
  - Offset constants OFF_TOHOST..OFF_WATCHDOG.
  - FSM enum {IDLE, WAIT, RESP}.
  - WDOG_CODE constant.
- Sub-module dv_sim_ctrl_fifo: synchronous FIFO parameterised on width/depth, with full/empty flags and push-when-full drop indication.

Test Plan:
- ACK_LATENCY=3; write 32'h1 to BASE+0x00 -> stall high for 3 cycles, ack in cycle accept+3, test_done_o=1, test_pass_o=1, test_code_o=0.
- Write 32'h2B to TOHOST, then write 32'h1 -> done=1, pass=0, code=31'h15; second write acked, flags unchanged.
- con_ready_i=0; push 17 bytes 'A'..'Q' to CONSOLE -> 17 acks, con_overflow_o=1 after the 17th. Release ready -> 16 bytes 'A'..'P' out in order.
- Read CYCLE_LO then CYCLE_HI around forced wrap (preload 32'hFFFF_FFFE) -> HI equals the value latched at the LO read, not the post-wrap value.
- Read BASE+0x18; write CYCLE_HI; write TOHOST with sel=4'h1 -> err each, no ack, no state change.
- Drop cyc in WAIT after a SCRATCH write of 32'hA5A5_A5A5 -> no ack, a subsequent read returns 32'hA5A5_A5A5. With DV_SIM_CTRL_WATCHDOG_EN, write 50 to 0x14 -> done, code=31'h7FFF_FFFF after 50 cycles.
